// File: rtl/main_mem_ctrl_pkg.sv
// Shared request/response payloads, op/mode encodings and helpers for the
// backing-memory controller that sits below the data cache.
package main_mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        op;
    logic [2:0]        mode_addr;
    logic              valid;
  } request_type;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
  } response_type;

  localparam logic [1:0] MEM_OP_READ  = 2'b10;
  localparam logic [1:0] MEM_OP_WRITE = 2'b01;
  localparam logic [1:0] MEM_OP_NOP   = 2'b11;

  localparam logic [2:0] MODE_WORD   = 3'b001;
  localparam logic [2:0] MODE_BYTE_U = 3'b011;
  localparam logic [2:0] MODE_BYTE_S = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} mem_ctrl_state_t;

  function automatic logic is_byte_mode(input logic [2:0] mode);
    return (mode == MODE_BYTE_U) || (mode == MODE_BYTE_S);
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] mode, input logic [1:0] lane);
    return is_byte_mode(mode) ? 4'(4'b0001 << lane) : 4'hF;
  endfunction

  // Little-endian lane select with zero/sign extension; word modes pass through.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [2:0] mode,
                                                    input logic [1:0] lane);
    logic [7:0] b;
    b = 8'(word >> {lane, 3'b000});
    case (mode)
      MODE_BYTE_U: return {24'h0, b};
      MODE_BYTE_S: return {{24{b[7]}}, b};
      default:     return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data store: byte-enabled synchronous write, combinational read.
module data_mem_array #(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata_c
);

  logic [31:0] store [DEPTH_WORDS];

  // Store contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) store[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata_c = store[idx];

endmodule

// File: rtl/main_mem_ctrl.sv
// Fixed-latency backing-memory controller: latches one cache request, waits
// LATENCY cycles, performs the word/byte access and pulses a registered ready.
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  request_type  mem_req,
  output response_type mem_resp,
  output logic         busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  mem_ctrl_state_t state_q, state_d;
  logic [3:0]      count_q, count_d;
  request_type     req_q, req_d;
  response_type    resp_q, resp_d;
  logic            busy_q, busy_d;

  request_type     acc_c;
  logic            access_c;
  logic            is_write_c;
  logic [31:0]     rdata_c;
  logic            addr_unused_c;

  // With LATENCY==1 the access happens on the accept edge, straight from mem_req.
  assign acc_c      = (state_q == IDLE) ? mem_req : req_q;
  assign is_write_c = (acc_c.op == MEM_OP_WRITE);

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .we      (access_c && is_write_c),
    .be      (byte_enable(acc_c.mode_addr, acc_c.addr[1:0])),
    .idx     (acc_c.addr[IDX_W+1:2]),
    .wdata   (is_byte_mode(acc_c.mode_addr) ? {4{acc_c.data[7:0]}} : acc_c.data),
    .rdata_c (rdata_c)
  );

  assign addr_unused_c = ^{acc_c.addr[ADDR_W-1:IDX_W+2], acc_c.valid};

  // Next-state, latency counter and request latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    req_d    = req_q;
    busy_d   = busy_q;
    access_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req.valid) begin
          req_d  = mem_req;
          busy_d = 1'b1;
          if (LATENCY <= 32'd1) begin
            access_c = 1'b1;
            state_d  = RESPOND;
          end else begin
            count_d = LAT_M1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        count_d = count_q - 4'd1;
        if (count_q <= 4'd1) begin
          access_c = 1'b1;
          state_d  = RESPOND;
        end
      end
      RESPOND: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response register: ready for one cycle, data only meaningful for reads.
  always_comb begin
    resp_d.data  = resp_q.data;
    resp_d.ready = 1'b0;
    if (access_c) begin
      resp_d.ready = 1'b1;
      resp_d.data  = (acc_c.op[0] == 1'b0)
                   ? load_extend(rdata_c, acc_c.mode_addr, acc_c.addr[1:0]) : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
    end
  end

  assign mem_resp = resp_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl with LATENCY=4, DEPTH_WORDS=1024.
module tb_main_mem_ctrl;
  import main_mem_ctrl_pkg::*;

  logic         clk;
  logic         rst;
  request_type  mem_req;
  response_type mem_resp;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  main_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_resp (mem_resp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge; optionally keep valid high with a junk
  // WRITE for 'hold' cycles afterwards. Observes 10 cycles after accept.
  task automatic do_req(input logic [1:0] op, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int hold,
                        output logic [31:0] rdata, output int lat,
                        output int pulses, output logic busy1);
    mem_req = '{addr: addr, data: data, op: op, mode_addr: mode, valid: 1'b1};
    @(posedge clk);
    rdata = 32'h0; lat = 0; pulses = 0; busy1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (mem_resp.ready) begin
        pulses++;
        if (lat == 0) begin
          lat   = k;
          rdata = mem_resp.data;
        end
      end
      if (k <= hold)
        mem_req = '{addr: 32'h20, data: 32'h5555_5555, op: MEM_OP_WRITE,
                    mode_addr: MODE_WORD, valid: 1'b1};
      else
        mem_req = '0;
    end
  endtask

  logic [31:0] rd;
  int          lat, pulses, abort_pulses;
  logic        b1;

  initial begin
    mem_req = '0;
    rst = 1'b1;
    #1 rst = 1'b0;

    // Reset held: outputs quiet even with a valid pulse.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ready", 32'(mem_resp.ready), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_data",  mem_resp.data, 32'h0);
      mem_req = '{addr: 32'h10, data: 32'h0, op: MEM_OP_READ, mode_addr: MODE_WORD,
                  valid: (i == 2)};
    end
    mem_req = '0;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Word write then read.
    do_req(MEM_OP_WRITE, MODE_WORD, 32'h10, 32'hDEAD_BEEF, 0, rd, lat, pulses, b1);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_pulses", 32'(pulses), 32'd1);
    check("wr_data0", rd, 32'h0);
    check("wr_busy", 32'(b1), 32'd1);
    do_req(MEM_OP_READ, MODE_WORD, 32'h10, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_pulses", 32'(pulses), 32'd1);
    check("rd_word", rd, 32'hDEAD_BEEF);

    // Byte lanes and extension on 0x11223344 at 0x20.
    do_req(MEM_OP_WRITE, MODE_WORD, 32'h20, 32'h1122_3344, 0, rd, lat, pulses, b1);
    do_req(MEM_OP_WRITE, MODE_BYTE_U, 32'h22, 32'h0000_00AA, 0, rd, lat, pulses, b1);
    check("bwr_pulses", 32'(pulses), 32'd1);
    do_req(MEM_OP_READ, MODE_WORD, 32'h20, 32'h0, 0, rd, lat, pulses, b1);
    check("bwr_word", rd, 32'h11AA_3344);
    do_req(MEM_OP_READ, MODE_BYTE_S, 32'h22, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_byte_s", rd, 32'hFFFF_FFAA);
    do_req(MEM_OP_READ, MODE_BYTE_U, 32'h22, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_byte_u", rd, 32'h0000_00AA);
    do_req(MEM_OP_READ, MODE_BYTE_S, 32'h20, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_lane0_s", rd, 32'h0000_0044);
    do_req(MEM_OP_READ, MODE_BYTE_U, 32'h23, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_lane3_u", rd, 32'h0000_0011);
    do_req(2'b00, MODE_WORD, 32'h23, 32'h0, 0, rd, lat, pulses, b1);
    check("rd_op00_unaligned", rd, 32'h11AA_3344);
    do_req(MEM_OP_NOP, MODE_WORD, 32'h20, 32'hFFFF_FFFF, 0, rd, lat, pulses, b1);
    check("nop_pulses", 32'(pulses), 32'd1);
    check("nop_data", rd, 32'h0);

    // Valid held with changing payload through WAIT and RESPOND.
    do_req(MEM_OP_READ, MODE_WORD, 32'h10, 32'h0, 4, rd, lat, pulses, b1);
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_latency", 32'(lat), 32'd4);
    check("busy_data", rd, 32'hDEAD_BEEF);
    do_req(MEM_OP_READ, MODE_WORD, 32'h20, 32'h0, 0, rd, lat, pulses, b1);
    check("busy_no_write", rd, 32'h11AA_3344);

    // Index wrap.
    do_req(MEM_OP_READ, MODE_WORD, 32'd4096 + 32'h10, 32'h0, 0, rd, lat, pulses, b1);
    check("wrap_read", rd, 32'hDEAD_BEEF);

    // Reset two cycles after accepting a write drops it.
    do_req(MEM_OP_WRITE, MODE_WORD, 32'h30, 32'h1234_5678, 0, rd, lat, pulses, b1);
    mem_req = '{addr: 32'h30, data: 32'h9999_9999, op: MEM_OP_WRITE,
                mode_addr: MODE_WORD, valid: 1'b1};
    @(posedge clk);
    @(negedge clk);
    mem_req = '0;
    abort_pulses = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_resp.ready) abort_pulses++;
      check("abort_busy", 32'(busy), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_resp.ready) abort_pulses++;
    end
    check("abort_pulses", 32'(abort_pulses), 32'd0);
    do_req(MEM_OP_READ, MODE_WORD, 32'h30, 32'h0, 0, rd, lat, pulses, b1);
    check("abort_old_data", rd, 32'h1234_5678);

    // Cache-style miss: write back dirty word, fetch refill, re-read.
    do_req(MEM_OP_WRITE, MODE_WORD, 32'h200, 32'h0BAD_C0DE, 0, rd, lat, pulses, b1);
    do_req(MEM_OP_WRITE, MODE_WORD, 32'h100, 32'hCAFE_F00D, 0, rd, lat, pulses, b1);
    check("wb_pulses", 32'(pulses), 32'd1);
    do_req(MEM_OP_READ, MODE_WORD, 32'h200, 32'h0, 0, rd, lat, pulses, b1);
    check("alloc_fetch", rd, 32'h0BAD_C0DE);
    do_req(MEM_OP_READ, MODE_WORD, 32'h100, 32'h0, 0, rd, lat, pulses, b1);
    check("wb_readback", rd, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
